// File: rtl/fb_pkg.sv
// Shared definitions for the edge pipeline frame-buffer writer: frame geometry
// defaults, the packed layout of a buffered pixel entry, and writer states.
package fb_pkg;

    localparam int FB_W      = 160;
    localparam int FB_H      = 120;
    localparam int FB_PIX    = FB_W * FB_H;
    localparam int FB_ADDR_W = 17;
    localparam int COL_W     = 24;

    // Entry layout, LSB first: colour, address, bank, last
    localparam int ENT_COL_LSB  = 0;
    localparam int ENT_ADDR_LSB = COL_W;

    function automatic int ent_bank_bit(int aw);
        return COL_W + aw;
    endfunction

    function automatic int ent_last_bit(int aw);
        return COL_W + aw + 1;
    endfunction

    function automatic int ent_width(int aw);
        return COL_W + aw + 2;
    endfunction

    localparam int FB_ENT_W = ent_width(FB_ADDR_W);

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } fb_state_t;

endpackage

// File: rtl/plot_fifo.sv
// Generic synchronous FIFO. DEPTH must be a power of 2 (pointers wrap
// naturally). A push into a full FIFO is taken only if a pop happens in the
// same cycle. head presents the oldest entry straight from storage.
module plot_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               rd_ptr;
    logic [AW-1:0]               wr_ptr;
    logic [AW:0]                 count;
    logic                        do_push;
    logic                        do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage and pointers; reset clears storage so head reads 0 when idle
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/edge_plot_fb_writer.sv
// Frame-buffer writer at the tail of the edge pipeline. Checks raster order of
// incoming plots, buffers accepted pixels and drains them into the RAM write
// port with a valid/ready handshake. Tracks completed frames and the bank the
// display reader should scan.
// Optional: DOUBLE_BUFFER_EN enables two alternating banks; without it a
// single bank is used and disp_bank stays 0.
module edge_plot_fb_writer
    import fb_pkg::*;
#(
    parameter int W          = FB_W,
    parameter int H          = FB_H,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = FB_ADDR_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [7:0]        x_s,
    input  logic [6:0]        y_s,
    input  logic [23:0]       colour_s,
    input  logic              plot_s,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    input  logic              wr_ready,
    output logic              disp_bank,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              ovf,
    output logic              sync_err,
    input  logic              clr_err
);

    localparam int EW       = ent_width(ADDR_W);
    localparam int BANK_BIT = ent_bank_bit(ADDR_W);
    localparam int LAST_BIT = ent_last_bit(ADDR_W);

    fb_state_t         state, state_nxt;
    logic [7:0]        ex;
    logic [6:0]        ey;
    logic              wr_bank;
    logic              in_range, is_match, is_origin, is_last, x_wrap;
    logic              accept, sync_ev, ovf_ev;
    logic              pop, full, empty;
    logic [ADDR_W-1:0] pix_addr;
    logic [EW-1:0]     push_ent, head;

    assign in_range  = (32'(x_s) < W) && (32'(y_s) < H);
    assign is_match  = in_range && (x_s == ex) && (y_s == ey);
    assign is_origin = (x_s == '0) && (y_s == '0);
    assign x_wrap    = (32'(x_s) == W - 1);
    assign is_last   = x_wrap && (32'(y_s) == H - 1);

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= WAIT_SOF;
        else         state <= state_nxt;
    end

    // Next state: (0,0) always (re)starts a frame; any other miss drops sync
    always_comb begin
        state_nxt = state;
        if (plot_s) begin
            case (state)
                WAIT_SOF: if (is_origin)               state_nxt = ACTIVE;
                default:  if (!is_match && !is_origin) state_nxt = WAIT_SOF;
            endcase
        end
    end

    // Outputs of the FSM: accept decision and sync error event
    always_comb begin
        accept  = 1'b0;
        sync_ev = 1'b0;
        if (plot_s) begin
            case (state)
                WAIT_SOF: accept = is_origin;
                default: begin
                    accept  = is_match || is_origin;
                    sync_ev = !is_match;
                end
            endcase
        end
    end

    // Expected coordinate advances from whatever was accepted, even when the
    // FIFO drops it, so an overflow never misaligns the frame
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ex <= '0;
            ey <= '0;
        end else if (accept) begin
            if (is_last) begin
                ex <= '0;
                ey <= '0;
            end else if (x_wrap) begin
                ex <= '0;
                ey <= y_s + 1'b1;
            end else begin
                ex <= x_s + 1'b1;
                ey <= y_s;
            end
        end
    end

`ifdef DOUBLE_BUFFER_EN
    // Write bank flips once the last pixel of a frame has been accepted
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                wr_bank <= 1'b0;
        else if (accept && is_last) wr_bank <= ~wr_bank;
    end
`else
    assign wr_bank = 1'b0;
`endif

    assign pix_addr = ADDR_W'(y_s) * ADDR_W'(W) + ADDR_W'(x_s)
                    + (wr_bank ? ADDR_W'(W * H) : '0);
    assign push_ent = {is_last, wr_bank, pix_addr, colour_s};
    assign pop      = !empty && wr_ready;
    assign ovf_ev   = accept && full && !pop;

    plot_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (accept),
        .pop    (pop),
        .din    (push_ent),
        .full   (full),
        .empty  (empty),
        .head   (head)
    );

    assign wr_en   = !empty;
    assign wr_addr = head[ENT_ADDR_LSB +: ADDR_W];
    assign wr_data = head[ENT_COL_LSB +: COL_W];

    // Frame completion is registered off the write of a last-tagged entry
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            disp_bank  <= 1'b0;
        end else begin
            frame_done <= pop && head[LAST_BIT];
            if (pop && head[LAST_BIT]) begin
                frame_cnt <= frame_cnt + 1'b1;
                disp_bank <= head[BANK_BIT];
            end
        end
    end

    // Sticky error flags; a new event wins over a coincident clear
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ovf      <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            ovf      <= (ovf & ~clr_err) | ovf_ev;
            sync_err <= (sync_err & ~clr_err) | sync_ev;
        end
    end

endmodule

// File: tb/tb_edge_plot_fb_writer.sv
// Self-checking bench for edge_plot_fb_writer: scoreboard of expected RAM
// writes plus a vector table for raster-order / error-flag sequences.
module tb_edge_plot_fb_writer;

`ifdef DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  x_s = '0;
    logic [6:0]  y_s = '0;
    logic [23:0] colour_s = '0;
    logic        plot_s = 1'b0;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic [23:0] wr_data;
    logic        wr_ready = 1'b1;
    logic        disp_bank;
    logic        frame_done;
    logic [7:0]  frame_cnt;
    logic        ovf;
    logic        sync_err;
    logic        clr_err = 1'b0;

    always #5 clock = ~clock;

    edge_plot_fb_writer dut (
        .clock      (clock),
        .resetn     (resetn),
        .x_s        (x_s),
        .y_s        (y_s),
        .colour_s   (colour_s),
        .plot_s     (plot_s),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .disp_bank  (disp_bank),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .ovf        (ovf),
        .sync_err   (sync_err),
        .clr_err    (clr_err)
    );

    typedef struct packed {
        logic [16:0] a;
        logic [23:0] d;
    } wr_t;

    typedef struct {
        int x;
        int y;
        bit clr;
        bit kept;
        bit sync;
    } vec_t;

    wr_t  q[$];
    wr_t  mon_e;
    vec_t tbl[9];
    int   vectors = 0;
    int   miscompares = 0;
    int   fd_pulses = 0;
    int   exp_bank = 0;
    int   last_bank = 0;
    int   pre_pulses;

    function automatic logic [16:0] exp_addr(int x, int y, int b);
        return 17'(y * 160 + x + (DB ? b * 19200 : 0));
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted write must match the oldest expected pixel
    always @(negedge clock) begin
        if (resetn) begin
            if (frame_done) fd_pulses++;
            if (wr_en && wr_ready) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected write: got addr %0d, want no write", wr_addr);
                end else begin
                    mon_e = q.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(mon_e.a));
                    chk("wr_data", 32'(wr_data), 32'(mon_e.d));
                end
            end
        end
    end

    task automatic drive(int x, int y, bit p, bit clr, bit kept);
        logic [23:0] c;
        c        = 24'($urandom);
        x_s      = 8'(x);
        y_s      = 7'(y);
        colour_s = c;
        plot_s   = p;
        clr_err  = clr;
        if (p && kept) begin
            q.push_back({exp_addr(x, y, exp_bank), c});
            if (x == 159 && y == 119) begin
                last_bank = exp_bank;
                exp_bank  = exp_bank ^ 1;
            end
        end
        @(posedge clock);
        #1;
        plot_s  = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic stream(int x0, int y0, int x1, int y1);
        for (int i = y0 * 160 + x0; i <= y1 * 160 + x1; i++)
            drive(i % 160, i / 160, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn  = 1'b0;
        plot_s  = 1'b0;
        clr_err = 1'b0;
        q.delete();
        repeat (2) @(posedge clock);
        #1;
        resetn    = 1'b1;
        exp_bank  = 0;
        last_bank = 0;
    endtask

    initial begin
        tbl[0] = '{x: 11,  y: 2, clr: 0, kept: 0, sync: 1};
        tbl[1] = '{x: 12,  y: 2, clr: 0, kept: 0, sync: 1};
        tbl[2] = '{x: 0,   y: 0, clr: 0, kept: 1, sync: 1};
        tbl[3] = '{x: 1,   y: 0, clr: 0, kept: 1, sync: 1};
        tbl[4] = '{x: 2,   y: 0, clr: 1, kept: 1, sync: 0};
        tbl[5] = '{x: 170, y: 5, clr: 1, kept: 0, sync: 1};
        tbl[6] = '{x: 3,   y: 0, clr: 1, kept: 0, sync: 0};
        tbl[7] = '{x: 0,   y: 0, clr: 0, kept: 1, sync: 0};
        tbl[8] = '{x: 1,   y: 0, clr: 0, kept: 1, sync: 0};

        #1;
        do_reset();
        chk("rst wr_en",      32'(wr_en), 0);
        chk("rst wr_addr",    32'(wr_addr), 0);
        chk("rst wr_data",    32'(wr_data), 0);
        chk("rst disp_bank",  32'(disp_bank), 0);
        chk("rst frame_done", 32'(frame_done), 0);
        chk("rst frame_cnt",  32'(frame_cnt), 0);
        chk("rst ovf",        32'(ovf), 0);
        chk("rst sync_err",   32'(sync_err), 0);

        // Two full frames, RAM always ready
        stream(0, 0, 159, 119);
        idle(4);
        chk("f1 frame_done pulses", 32'(fd_pulses), 1);
        chk("f1 frame_cnt",         32'(frame_cnt), 1);
        chk("f1 disp_bank",         32'(disp_bank), 0);
        chk("f1 pending writes",    32'(q.size()), 0);
        stream(0, 0, 159, 119);
        idle(4);
        chk("f2 frame_done pulses", 32'(fd_pulses), 2);
        chk("f2 frame_cnt",         32'(frame_cnt), 2);
        chk("f2 disp_bank",         32'(disp_bank), DB ? 1 : 0);
        chk("f2 sync_err",          32'(sync_err), 0);

        // Overflow: RAM stalled for 10 plots, only the first 4 survive
        wr_ready = 1'b0;
        for (int i = 0; i < 10; i++)
            drive(i, 0, 1'b1, 1'b0, i < 4);
        chk("ovf set", 32'(ovf), 1);
        wr_ready = 1'b1;
        stream(10, 0, 159, 119);
        idle(6);
        chk("ovf frame sync_err", 32'(sync_err), 0);
        chk("ovf frame_cnt",      32'(frame_cnt), 3);
        chk("ovf disp_bank",      32'(disp_bank), DB ? last_bank : 0);
        chk("ovf sticky",         32'(ovf), 1);
        chk("ovf pending writes", 32'(q.size()), 0);
        drive(0, 0, 1'b0, 1'b1, 1'b0);
        chk("ovf cleared", 32'(ovf), 0);

        // Late raster start and first-write latency
        do_reset();
        drive(5, 3, 1'b1, 1'b0, 1'b0);
        drive(6, 3, 1'b1, 1'b0, 1'b0);
        stream(0, 0, 2, 2);
        idle(3);
        chk("lat idle wr_en", 32'(wr_en), 0);
        drive(3, 2, 1'b1, 1'b0, 1'b1);
        chk("lat wr_en",   32'(wr_en), 1);
        chk("lat wr_addr", 32'(wr_addr), 323);
        stream(4, 2, 9, 2);

        // Order / range errors and flag clearing
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].x, tbl[i].y, 1'b1, tbl[i].clr, tbl[i].kept);
            chk($sformatf("tbl[%0d] sync_err", i), 32'(sync_err), 32'(tbl[i].sync));
        end
        idle(4);
        chk("tbl pending writes", 32'(q.size()), 0);

        // Asynchronous reset with entries pending
        wr_ready = 1'b0;
        drive(2, 0, 1'b1, 1'b0, 1'b0);
        drive(3, 0, 1'b1, 1'b0, 1'b0);
        drive(4, 0, 1'b1, 1'b0, 1'b0);
        chk("pre-reset wr_en", 32'(wr_en), 1);
        pre_pulses = fd_pulses;
        #2;
        resetn = 1'b0;
        #1;
        chk("async rst wr_en",      32'(wr_en), 0);
        chk("async rst frame_cnt",  32'(frame_cnt), 0);
        chk("async rst frame_done", 32'(frame_done), 0);
        q.delete();
        @(posedge clock);
        #1;
        resetn   = 1'b1;
        exp_bank = 0;
        wr_ready = 1'b1;
        drive(1, 0, 1'b1, 1'b0, 1'b0);
        drive(2, 0, 1'b1, 1'b0, 1'b0);
        drive(0, 0, 1'b1, 1'b0, 1'b1);
        drive(1, 0, 1'b1, 1'b0, 1'b1);
        idle(4);
        chk("post-rst pending writes", 32'(q.size()), 0);
        chk("post-rst no frame_done",  32'(fd_pulses), 32'(pre_pulses));
        chk("post-rst frame_cnt",      32'(frame_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
